systolic_2x2_sequencer: RTL and testbench

Operand sequencer and result collector for the 2x2 output-stationary systolic array. It accepts a pair of 2x2 matrices A and B through a valid/ready handshake, clears the array's accumulators, and streams one operand column/row per cycle into the array's a0/a1/b0/b1 edge inputs. It then captures the array's four accumulator outputs and presents C = A·B through a second valid/ready handshake. It sits between the job source and the array; the top level wires its array-side ports directly to the array instance.

---
 rtl/systolic_2x2_sequencer.sv | 166 ++++++++++++++++
 tb/tb_systolic_2x2_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/systolic_2x2_sequencer.sv
// Operand sequencer and result collector for a 2x2 output-stationary
// systolic array. Latches a job (A, B), clears the array accumulators,
// streams the k=0 and k=1 operand column/row pairs, waits one drain cycle,
// then holds C = A*B behind a valid/ready handshake until it is taken.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   S_IDLE  | in_ready high, waiting for a job
//   S_CLEAR | array accumulators held in reset for one cycle
//   S_FEED0 | k=0 operands on the array edges
//   S_FEED1 | k=1 operands on the array edges
//   S_DRAIN | operands zero, array sums final, captured at exit edge
//   S_DONE  | out_valid high, result held until out_ready
module systolic_2x2_sequencer #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid_i,
  output logic           in_ready_o,
  input  logic [W-1:0]   a00_i,
  input  logic [W-1:0]   a01_i,
  input  logic [W-1:0]   a10_i,
  input  logic [W-1:0]   a11_i,
  input  logic [W-1:0]   b00_i,
  input  logic [W-1:0]   b01_i,
  input  logic [W-1:0]   b10_i,
  input  logic [W-1:0]   b11_i,
  output logic           arr_rst_n_o,
  output logic [W-1:0]   arr_a0_o,
  output logic [W-1:0]   arr_a1_o,
  output logic [W-1:0]   arr_b0_o,
  output logic [W-1:0]   arr_b1_o,
  input  logic [2*W:0]   arr_o1_i,
  input  logic [2*W:0]   arr_o2_i,
  input  logic [2*W:0]   arr_o3_i,
  input  logic [2*W:0]   arr_o4_i,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output logic [2*W:0]   c00_o,
  output logic [2*W:0]   c01_o,
  output logic [2*W:0]   c10_o,
  output logic [2*W:0]   c11_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED0,
    S_FEED1,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t         state_q;
  logic [W-1:0]   a00_q, a01_q, a10_q, a11_q;
  logic [W-1:0]   b00_q, b01_q, b10_q, b11_q;
  logic           arr_rst_n_q;
  logic [W-1:0]   arr_a0_q, arr_a1_q, arr_b0_q, arr_b1_q;
  logic           out_valid_q;
  logic [2*W:0]   c00_q, c01_q, c10_q, c11_q;

  // Qualified with rst so a job can never be offered-and-accepted while the
  // block is held in reset.
  assign in_ready_o = rst && (state_q == S_IDLE);

  // Sequencer: state, latched job, registered array drive and result capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      a00_q       <= '0;
      a01_q       <= '0;
      a10_q       <= '0;
      a11_q       <= '0;
      b00_q       <= '0;
      b01_q       <= '0;
      b10_q       <= '0;
      b11_q       <= '0;
      arr_rst_n_q <= 1'b0;
      arr_a0_q    <= '0;
      arr_a1_q    <= '0;
      arr_b0_q    <= '0;
      arr_b1_q    <= '0;
      out_valid_q <= 1'b0;
      c00_q       <= '0;
      c01_q       <= '0;
      c10_q       <= '0;
      c11_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          arr_rst_n_q <= 1'b1;
          if (in_valid_i) begin
            a00_q       <= a00_i;
            a01_q       <= a01_i;
            a10_q       <= a10_i;
            a11_q       <= a11_i;
            b00_q       <= b00_i;
            b01_q       <= b01_i;
            b10_q       <= b10_i;
            b11_q       <= b11_i;
            arr_rst_n_q <= 1'b0;
            state_q     <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          arr_rst_n_q <= 1'b1;
          arr_a0_q    <= a00_q;
          arr_a1_q    <= a10_q;
          arr_b0_q    <= b00_q;
          arr_b1_q    <= b01_q;
          state_q     <= S_FEED0;
        end
        S_FEED0: begin
          arr_a0_q <= a01_q;
          arr_a1_q <= a11_q;
          arr_b0_q <= b10_q;
          arr_b1_q <= b11_q;
          state_q  <= S_FEED1;
        end
        S_FEED1: begin
          arr_a0_q <= '0;
          arr_a1_q <= '0;
          arr_b0_q <= '0;
          arr_b1_q <= '0;
          state_q  <= S_DRAIN;
        end
        S_DRAIN: begin
          c00_q       <= arr_o1_i;
          c01_q       <= arr_o2_i;
          c10_q       <= arr_o3_i;
          c11_q       <= arr_o4_i;
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          arr_rst_n_q <= 1'b1;
          arr_a0_q    <= '0;
          arr_a1_q    <= '0;
          arr_b0_q    <= '0;
          arr_b1_q    <= '0;
          out_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign arr_rst_n_o = arr_rst_n_q;
  assign arr_a0_o    = arr_a0_q;
  assign arr_a1_o    = arr_a1_q;
  assign arr_b0_o    = arr_b0_q;
  assign arr_b1_o    = arr_b1_q;
  assign out_valid_o = out_valid_q;
  assign c00_o       = c00_q;
  assign c01_o       = c01_q;
  assign c10_o       = c10_q;
  assign c11_o       = c11_q;

endmodule

// File: tb/tb_systolic_2x2_sequencer.sv
// Bench for systolic_2x2_sequencer: a behavioural 2x2 array stub closes the
// loop, expected C comes from plain matrix arithmetic on the offered job.
module tb_systolic_2x2_sequencer;

  localparam int W = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [W-1:0]  a00, a01, a10, a11, b00, b01, b10, b11;
  logic          arr_rst_n;
  logic [W-1:0]  arr_a0, arr_a1, arr_b0, arr_b1;
  logic [2*W:0]  acc0, acc1, acc2, acc3;
  logic          out_valid, out_ready;
  logic [2*W:0]  c00, c01, c10, c11;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  systolic_2x2_sequencer #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .a00_i(a00), .a01_i(a01), .a10_i(a10), .a11_i(a11),
    .b00_i(b00), .b01_i(b01), .b10_i(b10), .b11_i(b11),
    .arr_rst_n_o(arr_rst_n),
    .arr_a0_o(arr_a0), .arr_a1_o(arr_a1), .arr_b0_o(arr_b0), .arr_b1_o(arr_b1),
    .arr_o1_i(acc0), .arr_o2_i(acc1), .arr_o3_i(acc2), .arr_o4_i(acc3),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .c00_o(c00), .c01_o(c01), .c10_o(c10), .c11_o(c11)
  );

  // Array stub: PE(i,j) accumulates a_i*b_j each edge while its reset is high.
  always @(posedge clk) begin
    if (!arr_rst_n) begin
      acc0 <= '0; acc1 <= '0; acc2 <= '0; acc3 <= '0;
    end else begin
      acc0 <= acc0 + 17'(arr_a0) * 17'(arr_b0);
      acc1 <= acc1 + 17'(arr_a0) * 17'(arr_b1);
      acc2 <= acc2 + 17'(arr_a1) * 17'(arr_b0);
      acc3 <= acc3 + 17'(arr_a1) * 17'(arr_b1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic drive_job(input logic [31:0] am, input logic [31:0] bm);
    {a00, a01, a10, a11} = am;
    {b00, b01, b10, b11} = bm;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One full job: offer, follow each phase, hold in DONE for `hold` cycles.
  task automatic run_job(input logic [31:0] am, input logic [31:0] bm, input int hold);
    logic [7:0] x00, x01, x10, x11, y00, y01, y10, y11;
    int e00, e01, e10, e11;
    int n;
    {x00, x01, x10, x11} = am;
    {y00, y01, y10, y11} = bm;
    e00 = int'(x00) * int'(y00) + int'(x01) * int'(y10);
    e01 = int'(x00) * int'(y01) + int'(x01) * int'(y11);
    e10 = int'(x10) * int'(y00) + int'(x11) * int'(y10);
    e11 = int'(x10) * int'(y01) + int'(x11) * int'(y11);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive_job(am, bm);
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("accept_wait", 32'(n < 50), 32'd1);
    tick();
    // Accepted: scramble the bus while keeping in_valid high.
    drive_job($urandom, $urandom);
    chk("clear_in_ready", 32'(in_ready), 32'd0);
    chk("clear_arr_rst_n", 32'(arr_rst_n), 32'd0);
    chk("clear_ops", {arr_a0, arr_a1, arr_b0, arr_b1}, 32'd0);
    tick();
    drive_job($urandom, $urandom);
    chk("feed0_arr_rst_n", 32'(arr_rst_n), 32'd1);
    chk("feed0_ops", {arr_a0, arr_a1, arr_b0, arr_b1}, {x00, x10, y00, y01});
    chk("feed0_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("feed1_ops", {arr_a0, arr_a1, arr_b0, arr_b1}, {x01, x11, y10, y11});
    tick();
    chk("drain_ops", {arr_a0, arr_a1, arr_b0, arr_b1}, 32'd0);
    chk("drain_out_valid", 32'(out_valid), 32'd0);
    tick();
    chk("done_out_valid", 32'(out_valid), 32'd1);
    chk("done_in_ready", 32'(in_ready), 32'd0);
    chk("c00", 32'(c00), 32'(e00));
    chk("c01", 32'(c01), 32'(e01));
    chk("c10", 32'(c10), 32'(e10));
    chk("c11", 32'(c11), 32'(e11));
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_c00", 32'(c00), 32'(e00));
      chk("hold_c11", 32'(c11), 32'(e11));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_ops", {arr_a0, arr_a1, arr_b0, arr_b1}, 32'd0);
      chk("hold_array", 32'(acc3), 32'(e11));
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    tick();
    chk("release_out_valid", 32'(out_valid), 32'd0);
    chk("release_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    drive_job(32'd0, 32'd0);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_arr_rst_n", 32'(arr_rst_n), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_c00", 32'(c00), 32'd0);
    chk("rst_ops", {arr_a0, arr_a1, arr_b0, arr_b1}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("post_rst_arr_rst_n", 32'(arr_rst_n), 32'd1);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Basic with backpressure, then back-to-back identity job.
    run_job({8'd1, 8'd2, 8'd3, 8'd4}, {8'd5, 8'd6, 8'd7, 8'd8}, 5);
    run_job({8'd1, 8'd0, 8'd0, 8'd1}, {8'd9, 8'd0, 8'd0, 8'd9}, 0);
    // Max operands.
    run_job(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);

    // Reset during FEED1 discards the job.
    in_valid = 1'b1;
    drive_job({8'd7, 8'd7, 8'd7, 8'd7}, {8'd7, 8'd7, 8'd7, 8'd7});
    tick();
    tick();
    tick();
    in_valid = 1'b0;
    chk("mid_feed1_ops", {arr_a0, arr_a1, arr_b0, arr_b1}, {8'd7, 8'd7, 8'd7, 8'd7});
    rst = 1'b0;
    #1;
    chk("mid_rst_arr_rst_n", 32'(arr_rst_n), 32'd0);
    chk("mid_rst_ops", {arr_a0, arr_a1, arr_b0, arr_b1}, 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("mid_rel_arr_rst_n", 32'(arr_rst_n), 32'd1);
    chk("mid_rel_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("mid_no_result", 32'(out_valid), 32'd0);
    end
    run_job({8'd2, 8'd0, 8'd0, 8'd2}, {8'd3, 8'd1, 8'd1, 8'd3}, 0);

    // Randomized jobs against the arithmetic model.
    for (int j = 0; j < 12; j++)
      run_job($urandom, $urandom, int'($urandom_range(0, 3)));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
